// File: rtl/ofifo_deskew_pkg.sv
// rtl/ofifo_deskew_pkg.sv - shared sizing constants and helpers for the output deskew FIFO bank
//
// Purpose : default geometry of the output buffer bank and a ceil(log2) helper
//           used to size the per-column read/write pointers.
// Contents: COL, PSUM_BW, OFIFO_DEPTH defaults; clog2().

package ofifo_deskew_pkg;

    localparam int COL         = 8;
    localparam int PSUM_BW     = 16;
    localparam int OFIFO_DEPTH = 64;

    // ceil(log2(value)); returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int result;
        int remain;
        result = 0;
        remain = value - 1;
        while (remain > 0) begin
            result = result + 1;
            remain = remain >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/ofifo_deskew_if.sv
// rtl/ofifo_deskew_if.sv - array-edge / psum-path bus of the output deskew FIFO bank
//
// Purpose : bundles the column data/strobes coming from the array bottom edge
//           with the aligned-row side going to the psum SRAM controller.
// Signals : in[col*bw]   column data, column i on in[(i+1)*bw-1 : i*bw]
//           wr[col]      per-column write strobe
//           rd           pop one aligned row
//           out[col*bw]  registered popped row
//           o_valid      every column holds data
//           o_full       any column full
//           o_ready      ~o_full
//           o_ovf        sticky write-dropped flag
// Modports: master = array / controller side, slave = the FIFO bank.

interface ofifo_deskew_if
    import ofifo_deskew_pkg::*;
#(
    parameter int col = COL,
    parameter int bw  = PSUM_BW
);

    logic [col*bw-1:0] in;
    logic [col-1:0]    wr;
    logic              rd;
    logic [col*bw-1:0] out;
    logic              o_valid;
    logic              o_full;
    logic              o_ready;
    logic              o_ovf;

    modport master (
        output in,
        output wr,
        output rd,
        input  out,
        input  o_valid,
        input  o_full,
        input  o_ready,
        input  o_ovf
    );

    modport slave (
        input  in,
        input  wr,
        input  rd,
        output out,
        output o_valid,
        output o_full,
        output o_ready,
        output o_ovf
    );

endinterface

// File: rtl/ofifo_col.sv
// rtl/ofifo_col.sv - single-column synchronous FIFO of the output deskew bank
//
// Purpose : stores the psums of one array column in arrival order.
// Ports   : clk      rising-edge clock
//           reset    asynchronous active-high; clears pointers only
//           wr       write strobe, already qualified by the caller (never set while full)
//           rd       read strobe, already qualified by the caller (never set while empty)
//           in       write data
//           rd_data  entry at the read pointer (combinational, no output register)
//           o_empty  wptr == rptr
//           o_full   pointer MSBs differ, lower bits equal

module ofifo_col
    import ofifo_deskew_pkg::*;
#(
    parameter int bw    = PSUM_BW,
    parameter int depth = OFIFO_DEPTH
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr,
    input  logic          rd,
    input  logic [bw-1:0] in,
    output logic [bw-1:0] rd_data,
    output logic          o_empty,
    output logic          o_full
);

    localparam int aw = clog2(depth);

    // One extra MSB distinguishes full from empty; wrap is natural modulo 2*depth.
    localparam logic [aw:0] ptr_one = (aw + 1)'(1);

    logic [aw:0]   wptr;
    logic [aw:0]   rptr;
    logic [bw-1:0] mem [depth];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr) begin
                wptr <= wptr + ptr_one;
            end
            if (rd) begin
                rptr <= rptr + ptr_one;
            end
        end
    end

    // Storage is deliberately not reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (wr && !reset) begin
            mem[wptr[aw-1:0]] <= in;
        end
    end

    assign rd_data = mem[rptr[aw-1:0]];
    assign o_empty = (wptr == rptr);
    assign o_full  = (wptr[aw] != rptr[aw]) && (wptr[aw-1:0] == rptr[aw-1:0]);

endmodule

// File: rtl/ofifo_deskew.sv
// rtl/ofifo_deskew.sv - output-side deskew buffer bank between the systolic array and psum SRAM
//
// Purpose : captures each skewed array column into its own FIFO and releases a
//           full aligned row only when every column holds data.
// Ports   : clk    rising-edge clock
//           reset  asynchronous active-high reset (pointers, out, o_ovf)
//           bus    ofifo_deskew_if.slave: in/wr/rd in, out/o_valid/o_full/o_ready/o_ovf out
// Notes   : writes to a full column are dropped and latch o_ovf; a pop in the
//           same cycle does not free a slot for that write. out is registered
//           and shows the popped row one cycle after rd is accepted.

module ofifo_deskew
    import ofifo_deskew_pkg::*;
#(
    parameter int col   = COL,
    parameter int bw    = PSUM_BW,
    parameter int depth = OFIFO_DEPTH
) (
    input  logic            clk,
    input  logic            reset,
    ofifo_deskew_if.slave   bus
);

    logic [col-1:0]    col_empty;
    logic [col-1:0]    col_full;
    logic [col-1:0]    wr_acc;
    logic [col-1:0]    wr_drop;
    logic              rd_acc;
    logic [col*bw-1:0] row;
    logic [col*bw-1:0] out_q;
    logic              ovf_q;

    // Full is taken from registered pointer state, so a same-cycle pop never rescues a write.
    assign wr_acc  = bus.wr & ~col_full;
    assign wr_drop = bus.wr &  col_full;

    // One pop moves every column together, keeping the rows aligned.
    assign rd_acc  = bus.rd & bus.o_valid;

    for (genvar i = 0; i < col; i++) begin : g_col
        ofifo_col #(
            .bw    (bw),
            .depth (depth)
        ) u_col (
            .clk     (clk),
            .reset   (reset),
            .wr      (wr_acc[i]),
            .rd      (rd_acc),
            .in      (bus.in[i*bw +: bw]),
            .rd_data (row[i*bw +: bw]),
            .o_empty (col_empty[i]),
            .o_full  (col_full[i])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (rd_acc) begin
                out_q <= row;
            end
            if (|wr_drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign bus.out     = out_q;
    assign bus.o_valid = &(~col_empty);
    assign bus.o_full  = |col_full;
    assign bus.o_ready = ~bus.o_full;
    assign bus.o_ovf   = ovf_q;

endmodule

// File: tb/tb_ofifo_deskew.sv
// tb/tb_ofifo_deskew.sv - self-checking bench for ofifo_deskew against a queue-based reference model

module tb_ofifo_deskew;
    import ofifo_deskew_pkg::*;

    localparam int col   = 8;
    localparam int bw    = 16;
    localparam int depth = 64;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    ofifo_deskew_if #(.col(col), .bw(bw)) bus ();

    ofifo_deskew #(
        .col   (col),
        .bw    (bw),
        .depth (depth)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Reference model: one queue per column, expected out register and sticky flag.
    logic [bw-1:0]     mq [col][$];
    logic [col*bw-1:0] m_out;
    logic              m_ovf;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit m_valid();
        for (int i = 0; i < col; i++) begin
            if (mq[i].size() == 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic bit m_full();
        for (int i = 0; i < col; i++) begin
            if (mq[i].size() == depth) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < col; i++) mq[i].delete();
        m_out = '0;
        m_ovf = 1'b0;
    endtask

    // Applies one clock edge to the model using the inputs currently driven.
    task automatic model_edge();
        bit was_full [col];
        bit do_pop;
        do_pop = bus.rd && m_valid();
        for (int i = 0; i < col; i++) was_full[i] = (mq[i].size() == depth);
        if (do_pop) begin
            for (int i = 0; i < col; i++) m_out[i*bw +: bw] = mq[i].pop_front();
        end
        for (int i = 0; i < col; i++) begin
            if (bus.wr[i]) begin
                if (was_full[i]) m_ovf = 1'b1;
                else mq[i].push_back(bus.in[i*bw +: bw]);
            end
        end
    endtask

    task automatic check_outs(input string tag);
        check({tag, ".out"},     bus.out,     m_out);
        check({tag, ".o_valid"}, bus.o_valid, m_valid());
        check({tag, ".o_full"},  bus.o_full,  m_full());
        check({tag, ".o_ready"}, bus.o_ready, !m_full());
        check({tag, ".o_ovf"},   bus.o_ovf,   m_ovf);
    endtask

    task automatic cycle(input string tag, input logic [col-1:0] w,
                         input logic [col*bw-1:0] d, input logic r);
        bus.wr = w;
        bus.in = d;
        bus.rd = r;
        @(posedge clk);
        model_edge();
        #1;
        check_outs(tag);
    endtask

    function automatic logic [col*bw-1:0] rand_row();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Asynchronous reset asserted between edges, held with random traffic.
    task automatic do_reset(input int n);
        reset = 1'b1;
        model_reset();
        #1;
        check_outs("rst_async");
        repeat (n) begin
            bus.wr = col'($urandom);
            bus.in = rand_row();
            bus.rd = 1'($urandom);
            @(posedge clk);
            #1;
            check_outs("rst_hold");
        end
        reset  = 1'b0;
        bus.wr = '0;
        bus.rd = 1'b0;
    endtask

    logic [col*bw-1:0] d;
    logic [bw-1:0]     first_vals [col];
    logic [bw-1:0]     col0_first;

    initial begin
        reset  = 1'b1;
        bus.wr = '0;
        bus.rd = 1'b0;
        bus.in = '0;
        model_reset();

        // 1: reset with random traffic
        do_reset(6);
        check("rst.out_zero", bus.out, '0);
        check("rst.ready",    bus.o_ready, 1'b1);

        // 2: skewed column writes
        for (int i = 0; i < col; i++) begin
            d = '0;
            d[i*bw +: bw] = bw'(16'h0100 + i);
            cycle("skew_wr", col'(1) << i, d, 1'b0);
            check("skew.valid", bus.o_valid, (i == col - 1));
        end
        cycle("skew_rd", '0, '0, 1'b1);
        check("skew.row", bus.out,
              128'h0107_0106_0105_0104_0103_0102_0101_0100);
        check("skew.drained", bus.o_valid, 1'b0);

        // 3: fill column 0, overflow, FIFO order
        for (int k = 0; k < depth; k++) begin
            d = rand_row();
            if (k == 0) col0_first = d[bw-1:0];
            cycle("fill0", 8'h01, d, 1'b0);
        end
        check("fill0.full",  bus.o_full,  1'b1);
        check("fill0.ready", bus.o_ready, 1'b0);
        check("fill0.ovf",   bus.o_ovf,   1'b0);
        cycle("fill0_drop", 8'h01, rand_row(), 1'b0);
        check("fill0.ovf_set", bus.o_ovf, 1'b1);
        cycle("fill_rest", 8'hFE, rand_row(), 1'b0);
        cycle("fill0_rd", '0, '0, 1'b1);
        check("fill0.order", bus.out[bw-1:0], col0_first);

        // 4: rd ignored while one column is empty
        do_reset(2);
        d = rand_row();
        for (int i = 0; i < col; i++) first_vals[i] = d[i*bw +: bw];
        cycle("part_wr", 8'h7F, d, 1'b0);
        for (int k = 0; k < 5; k++) cycle("part_rd", '0, rand_row(), 1'b1);
        check("part.out_held", bus.out, '0);
        d = rand_row();
        first_vals[col-1] = d[(col-1)*bw +: bw];
        cycle("part_wr7", 8'h80, d, 1'b0);
        cycle("part_pop", '0, '0, 1'b1);
        for (int i = 0; i < col; i++) check("part.first", bus.out[i*bw +: bw], first_vals[i]);

        // 5: 200-row stream with rd held high
        do_reset(1);
        for (int r = 0; r < 203; r++) begin
            for (int i = 0; i < col; i++) d[i*bw +: bw] = bw'(r + i);
            cycle("stream", (r < 200) ? 8'hFF : 8'h00, d, 1'b1);
            if (r >= 1 && r <= 200) begin
                for (int i = 0; i < col; i++) check("stream.row", bus.out[i*bw +: bw], bw'(r - 1 + i));
            end
        end
        check("stream.ovf", bus.o_ovf, 1'b0);

        // 6: full bank, simultaneous pop and writes, then mid-stream reset
        do_reset(1);
        for (int k = 0; k < depth; k++) cycle("fillall", 8'hFF, rand_row(), 1'b0);
        check("fillall.full", bus.o_full, 1'b1);
        cycle("full_rw", 8'hFF, rand_row(), 1'b1);
        check("full_rw.ovf",  bus.o_ovf,  1'b1);
        check("full_rw.occ",  mq[0].size(), 63);
        check("full_rw.full", bus.o_full, 1'b0);
        cycle("mid", 8'hFF, rand_row(), 1'b1);
        do_reset(2);
        check("mid.valid", bus.o_valid, 1'b0);

        // Random traffic with occasional resets
        for (int k = 0; k < 2500; k++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset($urandom_range(1, 3));
            end else begin
                cycle("rand", col'($urandom) | col'($urandom), rand_row(),
                      1'($urandom_range(0, 9) < 4));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ofifo_deskew.md
Name: ofifo_deskew

Overview:
- Output-side buffer bank for the systolic array; the counterpart of the skewed-read input buffer bank.
- Each array column emits psums on its own skewed cycle. This block captures each column independently into a per-column FIFO.
- A full aligned row is released to the accumulation/SRAM write path only when every column holds data.
- Sits between the array's bottom edge and the psum SRAM controller.

Parameters:
col, 8, number of array columns (one FIFO each)
bw, 16, psum width per column in bits
depth, 64, entries per column FIFO; must be a power of two >= 2

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
in  input  col*bw  column data; column i on in[(i+1)*bw-1 : i*bw]
wr  input  col  per-column write strobe; wr[i] writes column i
rd  input  1  pop one aligned row from all columns
out  output  col*bw  registered popped row, same column packing as in
o_valid  output  1  every column FIFO non-empty (a full row is available)
o_full  output  1  any column FIFO full
o_ready  output  1  ~o_full
o_ovf  output  1  sticky overflow: a write was dropped

Behaviour:
- Reset is asynchronous and active-high. It clears all read/write pointers, out, and o_ovf to 0. Array contents are not cleared.
- After reset: o_valid=0, o_full=0, o_ready=1, o_ovf=0, out=0.
- Pointers are log2(depth)+1 bits.
  - Column empty: wptr==rptr.
  - Column full: MSBs differ and lower bits are equal.
  - Wrap-around is natural modulo 2*depth.
- Column write: accepted when wr[i] & ~full[i], with full[i] sampled from the registered state at the current edge. The entry is stored at wptr[i] and wptr[i] increments.
- Write to a full column: dropped with no pointer change, and o_ovf is set to 1 on that edge. o_ovf stays 1 until reset.
  - This holds even if rd pops that column in the same cycle; there is no same-cycle read-frees-slot bypass.
- Columns are fully independent on the write side. Any subset of wr bits may be high in any cycle.
- o_valid = &(~empty). It is combinational from the pointers.
- o_full = |full. o_ready = ~o_full. Upstream treats o_ready=0 as "stop issuing array outputs".
- Read accepted when rd & o_valid:
  - all col rptrs increment together;
  - the row at the old rptrs is loaded into out on the same edge.
  - Latency: out shows the popped row the cycle after rd is sampled high.
- rd while o_valid=0: ignored. No pointer movement, out holds.
- out holds its last popped value whenever no read is accepted.
- Simultaneous accepted write and read on the same column: both take effect and occupancy is unchanged.
- No write-to-read fall-through: a row written at edge t is first poppable at edge t+1 (o_valid sampled after edge t).
- Reset asserted mid-stream: immediately empties all columns and clears flags. Writes/reads coinciding with the reset edge are discarded.

Decomposition:
- Shared package constants:
  - default COL=8, PSUM_BW=16, OFIFO_DEPTH=64;
  - function clog2 for pointer sizing.
- Sub-module ofifo_col: a single-column synchronous FIFO.
  - Ports: clk, reset, wr, rd, in[bw], rd_data[bw], o_empty, o_full.
  - No output register inside it.
  - Instantiated col times in a generate loop.
- Top level owns:
  - rd gating (rd & o_valid broadcast to all columns);
  - write gating;
  - the out register;
  - the sticky o_ovf.

Test Plan:
1. Reset with random in/wr/rd toggling -> out=0, o_valid=0, o_full=0, o_ready=1, o_ovf=0 during and after reset.
2. Skewed write: wr[i] pulsed at cycle t+i with in column i = 16'h0100+i (i=0..7) -> o_valid=0 until after the edge at t+7, then 1. rd one cycle later -> next cycle out = {16'h0107,...,16'h0100}, o_valid=0.
3. 64 writes to column 0 only -> o_full=1, o_ready=0, o_valid=0. 65th write dropped and o_ovf=1. Then one write to each of columns 1..7 and rd -> out column 0 = first value written (FIFO order kept).
4. rd asserted for 5 cycles with o_valid=0 (columns 0..6 loaded, column 7 empty) -> out unchanged, no pops. Later writing column 7 gives o_valid=1 and the first pop returns the original first entries.
5. Stream 200 rows with all wr bits high every cycle and rd held high -> steady 1 row/cycle after initial fill. Values (row index + column) emerge in order across pointer wrap. o_full never asserts, o_ovf=0.
6. All columns at 64 entries; rd and wr=8'hFF in the same cycle -> pop accepted, writes dropped, o_ovf=1, occupancy 63. Then assert reset mid-stream -> all flags/out 0, o_valid=0 immediately.
